alu_mul_seq: RTL
================

Name: alu_mul_seq

Overview:
- Multi-cycle sequencer that computes RV32M MUL (low 32 bits of rs1*rs2) by driving the single shared ALU through shift-and-add steps.
- Sits in EX between the EX-stage operand muxes and the ALU instance. It owns the ALU ports while a multiply runs and passes EX operands straight through when idle.
- Raises stall to freeze the pipeline until the product is ready.

Parameters:
- XLEN, 32, datapath width; must equal ALU operand width.
- SELW, 4, width of the ALU select bus.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_a  in  XLEN  EX-stage operand A (pass-through path).
- ex_b  in  XLEN  EX-stage operand B (pass-through path).
- ex_sel  in  SELW  EX-stage ALU select (pass-through path).
- start  in  1  request a multiply; sampled only in IDLE.
- flush  in  1  abort the current multiply.
- op_a  in  XLEN  multiplicand, sampled on the accept edge.
- op_b  in  XLEN  multiplier, sampled on the accept edge.
- alu_a  out  XLEN  to ALU A.
- alu_b  out  XLEN  to ALU B.
- alu_sel  out  SELW  to ALU select.
- alu_out  in  XLEN  from ALU result.
- busy  out  1  high in every state except IDLE.
- stall  out  1  equals busy; the pipeline holds while it is high.
- done  out  1  one-cycle pulse, product valid.
- result  out  XLEN  product register.

Behaviour:
- Reset, asynchronous: state=IDLE, busy=0, done=0, result=0. Internal registers P, M, Q are cleared to 0.
- ALU select codes: ADD=4'b0000, SUB=4'b0001, SLL=4'b0010.

IDLE:
- ALU ports combinationally equal ex_a, ex_b and ex_sel.
- When start=1 and flush=0 at a rising edge (the accept edge): M<=op_a, Q<=op_b, P<=0.
- If op_a==0 or op_b==0, next state is DONE.
- Otherwise next state is ADD if op_b[0]=1, else SHIFT.

ADD:
- Drive alu_a=P, alu_b=M, alu_sel=ADD.
- P<=alu_out, which wraps mod 2^XLEN. Next state is SHIFT.

SHIFT:
- Drive alu_a=M, alu_b=1, alu_sel=SLL. M<=alu_out, Q<=Q>>1.
- If (Q>>1)==0, next state is DONE.
- Otherwise next state is ADD if Q[1]=1, else SHIFT.

DONE:
- result<=P, written on the edge that enters DONE so it is valid while done=1.
- done=1 for exactly this cycle; busy stays 1. Next state is IDLE.
- While in DONE, ALU ports drive ex_a, ex_b and ex_sel.

Timing and boundaries:
- Cycles spent in ADD+SHIFT = (msb index of op_b + 1) + popcount(op_b). done is asserted in the cycle after the last of these. The maximum is 64 cycles, for op_b=0xFFFFFFFF.
- Zero operand: done is asserted in the cycle right after the accept edge, result=0.
- start while busy=1, including the DONE cycle: ignored, with no queueing.
- flush in any non-IDLE state: next state is IDLE, done is not asserted, result keeps its previous value.
- flush together with start in IDLE: flush wins and nothing is accepted.
- Asynchronous reset mid-operation: immediately IDLE with all outputs at reset values. Operation resumes on the first edge after rst deasserts.
- Op_a and op_b are not required to stay stable after the accept edge.
- ALU outputs Zero and Negativo are not used by this block.

Decomposition:
- Shared header/package alu_defs holds:
  - the ALU select codes (ADD, SUB, SLL, XOR=4'b0101, OR=4'b0110, AND=4'b0111);
  - the state encoding for alu_mul_seq (IDLE, ADD, SHIFT, DONE as 2-bit localparams).
- No sub-module: the ALU stays instantiated at EX level, and the ownership mux is an always-comb block inside alu_mul_seq.

Test Plan:
- op_a=3, op_b=5, start for one cycle: states go ADD,SHIFT,SHIFT,ADD,SHIFT. done is asserted 6 cycles after the accept edge, result=15, busy falls one cycle later.
- op_a=0, op_b=0x1234: done is asserted in the cycle after accept, result=0, no ALU ADD/SHIFT cycles.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF: 64 ADD/SHIFT cycles, then result=0x00000001. Also op_a=0x80000000, op_b=2 gives result=0 (wrap).
- Pass-through in IDLE with ex_a=7, ex_b=2, ex_sel=SUB: alu_a=7, alu_b=2, alu_sel=0001, stall=0. During a multiply, the ALU ports ignore ex_*.
- Assert start again 3 cycles into 3*5: ignored, and a single done with result=15. Then assert flush 2 cycles into 7*9: next cycle busy=0, no done, result stays 15.
- Pulse rst in the middle of a 0xFFFFFFFF multiply: outputs go to 0 immediately without a clock edge. A following 6*7 yields result=42.

Source files
------------

// File: rtl/alu_defs.sv
// Shared ALU select codes and multiply-sequencer state encoding.
package alu_defs;

  localparam int unsigned ALU_SELW = 4;

  localparam logic [ALU_SELW-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_SELW-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_SELW-1:0] ALU_SLL = 4'b0010;
  localparam logic [ALU_SELW-1:0] ALU_XOR = 4'b0101;
  localparam logic [ALU_SELW-1:0] ALU_OR  = 4'b0110;
  localparam logic [ALU_SELW-1:0] ALU_AND = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add MUL sequencer that borrows the shared EX-stage ALU while a
// multiply runs and passes EX operands through to it otherwise.
module alu_mul_seq
  import alu_defs::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SELW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] ex_a,
  input  logic [XLEN-1:0] ex_b,
  input  logic [SELW-1:0] ex_sel,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [SELW-1:0] alu_sel,
  input  logic [XLEN-1:0] alu_out,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mul_state_t      state, state_nx;
  logic [XLEN-1:0] p, m, q;
  logic [XLEN-1:0] q_shr;
  logic            accept;

  assign q_shr  = q >> 1;
  assign accept = start && !flush;

  // Next state and ALU ownership mux; EX operands reach the ALU in IDLE and DONE.
  always_comb begin
    state_nx = state;
    alu_a    = ex_a;
    alu_b    = ex_b;
    alu_sel  = ex_sel;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (op_a == '0 || op_b == '0) state_nx = ST_DONE;
          else if (op_b[0])             state_nx = ST_ADD;
          else                          state_nx = ST_SHIFT;
        end
      end
      ST_ADD: begin
        alu_a    = p;
        alu_b    = m;
        alu_sel  = SELW'(ALU_ADD);
        state_nx = ST_SHIFT;
      end
      ST_SHIFT: begin
        alu_a   = m;
        alu_b   = XLEN'(1);
        alu_sel = SELW'(ALU_SLL);
        if (q_shr == '0) state_nx = ST_DONE;
        else if (q[1])   state_nx = ST_ADD;
        else             state_nx = ST_SHIFT;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (flush && state != ST_IDLE) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      p      <= '0;
      m      <= '0;
      q      <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            m <= op_a;
            q <= op_b;
            p <= '0;
          end
        end
        ST_ADD: begin
          if (!flush) p <= alu_out;
        end
        ST_SHIFT: begin
          if (!flush) begin
            m <= alu_out;
            q <= q_shr;
          end
        end
        default: ;
      endcase
      // Capture on the edge entering DONE; a zero operand skips straight from IDLE.
      if (state_nx == ST_DONE && state != ST_DONE)
        result <= (state == ST_IDLE) ? '0 : p;
    end
  end

  assign busy  = (state != ST_IDLE);
  assign stall = busy;
  assign done  = (state == ST_DONE);

endmodule
